// File: rtl/la_pkg.sv
// Shared types and constants for the logic analyzer pattern path.
package la_pkg;

    localparam int DATA_W    = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;
    localparam int DEF_HW    = 4;

    // Playback controller states.
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // One table entry: the value to drive and how many extra cycles to hold it.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEF_HW-1:0] hold;
    } entry_t;

endpackage

// File: rtl/pattern_table.sv
// Register-array pattern storage: one write port, one combinational read port.
// A synchronous reset clears every entry to value 0, hold 0.
module pattern_table
    import la_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int HW    = DEF_HW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [HW-1:0]     wr_hold,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [HW-1:0]     rd_hold
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [HW-1:0]     hold_mem [DEPTH];

    // Storage update: full clear on reset, otherwise a single-entry write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                hold_mem[i] <= '0;
            end
        end else if (wr_en) begin
            data_mem[wr_addr] <= wr_data;
            hold_mem[wr_addr] <= wr_hold;
        end
    end

    // Asynchronous read so the controller can load the next entry in the same cycle.
    always_comb begin
        rd_data = data_mem[rd_addr];
        rd_hold = hold_mem[rd_addr];
    end

endmodule

// File: rtl/pattern_generator.sv
// Pattern generator: replays the programmed table onto out_data, holding each
// entry for hold+1 cycles, single-shot or looped, with a per-pass marker.
//
// Handshake: there is no backpressure. out_valid qualifies out_data on every
// cycle it is high; marker and done are single-cycle pulses aligned with the
// data they describe. start is a level sampled only in IDLE, stop is a level
// that wins over start and over any advance or wrap.
module pattern_generator
    import la_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int HW    = DEF_HW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [HW-1:0]     wr_hold,
    input  logic [AW-1:0]     last_idx,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              marker,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [AW-1:0]     last_q, last_d;
    logic              loop_q, loop_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d, marker_d, busy_d, done_d;

    logic              tbl_we;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [HW-1:0]     rd_hold;
    logic              at_last;

    // The table is frozen while playing; writes are only accepted in IDLE.
    assign tbl_we    = wr_en && (state_q == IDLE);
    assign at_last   = (idx_q == last_q);
    assign dbg_state = state_q;

    // Read address: entry 0 when starting or wrapping, otherwise the next entry.
    always_comb begin
        rd_addr = '0;
        if (state_q == PLAY && !at_last) begin
            rd_addr = idx_q + AW'(1);
        end
    end

    pattern_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .HW    (HW)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tbl_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_hold (wr_hold),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_hold (rd_hold)
    );

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        last_d   = last_q;
        loop_d   = loop_q;
        data_d   = out_data;
        valid_d  = out_valid;
        busy_d   = busy;
        marker_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !stop) begin
                    state_d  = PLAY;
                    last_d   = last_idx;
                    loop_d   = loop;
                    idx_d    = '0;
                    hold_d   = rd_hold;
                    data_d   = rd_data;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    marker_d = 1'b1;
                end
            end

            PLAY: begin
                if (stop) begin
                    // Abort: out_data keeps its last value.
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (!at_last) begin
                    idx_d  = idx_q + AW'(1);
                    hold_d = rd_hold;
                    data_d = rd_data;
                end else if (loop_q) begin
                    // Wrap straight into entry 0 with no gap cycle.
                    idx_d    = '0;
                    hold_d   = rd_hold;
                    data_d   = rd_data;
                    marker_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            marker    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            loop_q    <= loop_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            marker    <= marker_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Testbench for pattern_generator: scenario tasks checked against a
// sequence-level reference model of the programmed table.
module tb_pattern_generator;
    import la_pkg::*;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [3:0]        wr_hold;
    logic [3:0]        last_idx;
    logic              loop;
    logic              start;
    logic              stop;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              marker;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference table contents and expected output stream {marker, data}.
    entry_t      m_tab [16];
    logic [8:0]  exp_q [$];

    pattern_generator dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_hold   (wr_hold),
        .last_idx  (last_idx),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .marker    (marker),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_tab[i].data = 8'h00;
            m_tab[i].hold = 4'h0;
        end
    endtask

    task automatic write_entry(input int addr, input logic [7:0] d, input logic [3:0] h);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr[3:0];
        wr_data = d;
        wr_hold = h;
        @(negedge clk);
        wr_en   = 1'b0;
        m_tab[addr].data = d;
        m_tab[addr].hold = h;
    endtask

    task automatic check_idle(input string name, input logic [7:0] exp_data, input logic exp_done);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || marker !== 1'b0 || done !== exp_done
            || out_data !== exp_data) begin
            errors++;
            $display("FAIL %s: valid=%b busy=%b marker=%b done=%b data=%h, required valid=0 busy=0 marker=0 done=%b data=%h",
                     name, out_valid, busy, marker, done, out_data, exp_done, exp_data);
        end
    endtask

    // Plays the table through the DUT and compares each cycle to the model.
    // Looped runs are ended with stop after `passes` passes. disturb_at >= 0
    // injects a write to entry 1 plus a start pulse at that playback cycle.
    task automatic run_pattern(input int last, input bit lp, input int passes,
                               input int disturb_at, input string name);
        int          n;
        logic [8:0]  exp;
        logic [7:0]  last_data;
        exp_q.delete();
        for (int p = 0; p < (lp ? passes : 1); p++)
            for (int i = 0; i <= last; i++)
                for (int h = 0; h <= int'(m_tab[i].hold); h++)
                    exp_q.push_back({(i == 0 && h == 0), m_tab[i].data});
        n = exp_q.size();
        last_data = 8'h00;
        @(negedge clk);
        last_idx = last[3:0];
        loop     = lp;
        start    = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == disturb_at + 1) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            // Inputs changed here must not affect the run.
            last_idx = 4'($urandom_range(0, 15));
            loop     = 1'($urandom_range(0, 1));
            exp = exp_q.pop_front();
            last_data = exp[7:0];
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0
                || {marker, out_data} !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: valid=%b busy=%b done=%b marker=%b data=%h, required valid=1 busy=1 done=0 marker=%b data=%h",
                         name, k, out_valid, busy, done, marker, out_data, exp[8], exp[7:0]);
            end
            if (k == disturb_at) begin
                wr_en   = 1'b1;
                wr_addr = 4'd1;
                wr_data = 8'h00;
                wr_hold = 4'h0;
                start   = 1'b1;
            end
        end
        if (lp) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            check_idle({name, " stop"}, last_data, 1'b0);
        end else begin
            @(negedge clk);
            check_idle({name, " done"}, last_data, 1'b1);
            @(negedge clk);
            check_idle({name, " after done"}, last_data, 1'b0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset outputs", 8'h00, 1'b0);
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset state: got %0d required %0d", dbg_state, IDLE);
        end
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle cycle %0d: valid=%b busy=%b required 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic load_basic();
        write_entry(0, 8'hA5, 4'd0);
        write_entry(1, 8'h3C, 4'd2);
        write_entry(2, 8'hFF, 4'd1);
    endtask

    task automatic test_basic();
        load_basic();
        run_pattern(2, 1'b0, 1, -1, "basic");
    endtask

    task automatic test_loop();
        run_pattern(2, 1'b1, 2, -1, "loop");
    endtask

    task automatic test_stop_priority();
        @(negedge clk);
        last_idx = 4'd2;
        loop     = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (out_data !== 8'h3C || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stop pre: data=%h valid=%b required 3c 1", out_data, out_valid);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_idle("stop in hold", 8'h3C, 1'b0);
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        check_idle("start+stop idle", 8'h3C, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check_idle("still idle", 8'h3C, 1'b0);
    endtask

    task automatic test_ignored_controls();
        run_pattern(2, 1'b0, 1, 1, "busy write/start");
        run_pattern(2, 1'b0, 1, -1, "table unchanged");
    endtask

    task automatic test_edge_lengths();
        write_entry(0, 8'h5A, 4'd0);
        run_pattern(0, 1'b1, 8, -1, "single entry loop");
        for (int i = 0; i < 16; i++) write_entry(i, 8'(8'h10 + i * 7), 4'd0);
        run_pattern(15, 1'b0, 1, -1, "full depth");
        run_pattern(15, 1'b1, 2, -1, "full depth loop");
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 16; i++)
                write_entry(i, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 3)));
            run_pattern($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                        $urandom_range(1, 3), -1, "random");
        end
    endtask

    task automatic test_mid_reset();
        load_basic();
        @(negedge clk);
        last_idx = 4'd2;
        loop     = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid reset", 8'h00, 1'b0);
        model_clear();
        run_pattern(3, 1'b0, 1, -1, "cleared table");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_hold = '0;
        last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_loop();
        test_stop_priority();
        test_ignored_controls();
        test_edge_lengths();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
- Stimulus source for the logic analyzer: the transmit-side counterpart of the pattern detector.
- Replays a small programmed table of 8-bit values onto an output bus. Each value is held for a programmable number of cycles.
- Supports single-shot or looped playback, with a marker pulse at the start of every pass.
- Drives loopback/self-test data into the capture path, or external pins via the top-level mux.

Parameters:
- DEPTH, 16, number of table entries (power of two).
- AW, 4, address width; equals log2(DEPTH).
- HW, 4, hold-count width; an entry is presented for hold+1 cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  table write strobe
- wr_addr  input  AW  table write address
- wr_data  input  8  value to store
- wr_hold  input  HW  hold count to store with the value
- last_idx  input  AW  index of the final entry played; sampled on start
- loop  input  1  1 = wrap to entry 0 after last_idx; sampled on start
- start  input  1  begin playback (level, acted on in IDLE only)
- stop  input  1  abort playback
- out_data  output  8  generated data
- out_valid  output  1  out_data is being driven by playback
- marker  output  1  1-cycle pulse when entry 0 is first presented in a pass
- busy  output  1  state is PLAY
- done  output  1  1-cycle pulse on natural completion (non-loop)

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE.
  - out_data=0, out_valid=0, marker=0, busy=0, done=0.
  - Index and hold counters = 0.
  - All table entries cleared to value 0, hold 0.
- Table storage:
  - DEPTH x (8+HW) register array.
  - wr_en in IDLE writes {wr_data, wr_hold} at wr_addr at the clock edge.
  - wr_en while busy is ignored; the table is stable during playback.
- FSM states: IDLE, PLAY. All outputs are registered.
- IDLE -> PLAY when start=1 and stop=0. Same edge:
  - latch last_idx and loop.
  - idx=0, hold_cnt=hold[0].
  - out_data=data[0], out_valid=1, marker=1, busy=1.
- Latency: first value is visible the cycle after start is sampled.
- PLAY, each cycle:
  - If hold_cnt != 0: decrement hold_cnt, keep out_data, marker=0.
  - Else if idx != latched last_idx: idx+1, load hold_cnt and out_data from the new entry.
  - Else if loop: idx=0, load entry 0, marker=1.
  - Else: next state IDLE, out_valid=0, busy=0, done=1 for one cycle. out_data keeps the last value.
- Entry i is therefore visible for exactly hold[i]+1 cycles. Consecutive entries are back-to-back with no gap cycle, including across the loop wrap.
- stop=1 in PLAY: next cycle IDLE, out_valid=0, busy=0, marker=0, done=0. out_data keeps its value. stop beats any simultaneous advance or wrap.
- stop=1 and start=1 together in IDLE: stop wins, remain IDLE.
- start while busy: ignored. No restart, no re-latching of last_idx or loop.
- last_idx=0: single-entry pattern. With loop=1, marker pulses every hold[0]+1 cycles.
- Mid-operation reset: state returns to IDLE and the table is cleared.
- The index counter is AW bits. last_idx=DEPTH-1 wraps naturally to 0 only via the loop path.

Decomposition:
- Shared package `la_pkg`:
  - state enum {IDLE, PLAY}.
  - constants DATA_W=8, default DEPTH, HW.
  - table-entry struct {data[7:0], hold[HW-1:0]}.
- One natural sub-module: `pattern_table`, the register-array storage with a synchronous-reset clear, a write port and a combinational read port.
- The FSM and counters stay in pattern_generator.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0. start held low 10 cycles -> out_valid stays 0.
- Basic play: write {0xA5,h0},{0x3C,h2},{0xFF,h1}, last_idx=2, loop=0, start pulse. Required response:
  - next cycle: out_data=A5 with marker=1.
  - then 3C for 3 cycles, then FF for 2 cycles.
  - then out_valid=0, done=1 for one cycle, out_data=FF.
- Loop: same table, loop=1, run 2 passes -> marker pulses exactly 6 cycles apart. No gap between FF and A5. done never asserts.
- Stop and priority: during the 3C hold, assert stop -> next cycle out_valid=0, busy=0, done=0. start and stop together in IDLE -> stays IDLE.
- Ignored controls: while busy, wr_en to entry 1 with 0x00, plus a start pulse -> table unchanged (a second run still outputs 3C), no restart.
- Edge lengths: last_idx=0, hold[0]=0, loop=1 -> out_data constant, marker=1 every cycle. last_idx=15 with all holds 0 -> 16 distinct values, then done.
